// File: rtl/ultrasonic_scan_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonic_scan_scheduler_pkg
//  Description : Shared state encoding and 50 MHz default timing constants for
//                the round-robin ultrasonic ranging scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package ultrasonic_scan_scheduler_pkg;

    // Scheduler states; 3-bit explicit encoding
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        REPORT    = 3'd4,
        GUARD     = 3'd5
    } scan_state_t;

    // Default timing for a 50 MHz clock
    localparam int C_DEF_N_SENSORS      = 4;
    localparam int C_DEF_TRIG_CYCLES    = 500;        // 10 us trigger pulse
    localparam int C_DEF_CYCLES_PER_CM  = 2900;       // 58 us of echo per cm
    localparam int C_DEF_TIMEOUT_CYCLES = 1_500_000;  // 30 ms echo window
    localparam int C_DEF_GUARD_CYCLES   = 3_000_000;  // 60 ms crosstalk guard
    localparam int C_DEF_DIST_W         = 12;

    // Larger of two integers, used to size shared counters
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ultrasonic_scan_scheduler_echo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : echo_sync
//  Description : Two-flop synchronizer for one asynchronous echo pin, with
//                registered single-cycle rise and fall pulses. An edge on the
//                pin shows up on rise/fall three clocks after the pin change.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo_in,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Edge detection on the synchronized level
    always_comb begin
        rise_d = sync_q & ~prev_q;
        fall_d = ~sync_q & prev_q;
    end

    // Synchronizer chain plus registered edge pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= echo_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/ultrasonic_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonic_scan_scheduler
//  Description : Round-robin scheduler for N HC-SR04-style sensors sharing one
//                echo timer. Fires one trigger at a time, times the selected
//                echo, converts it to cm and emits one tagged result per ping,
//                followed by a guard gap against acoustic crosstalk.
//  Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_scan_scheduler
    import ultrasonic_scan_scheduler_pkg::*;
#(
    parameter int N_SENSORS      = C_DEF_N_SENSORS,
    parameter int TRIG_CYCLES    = C_DEF_TRIG_CYCLES,
    parameter int CYCLES_PER_CM  = C_DEF_CYCLES_PER_CM,
    parameter int TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES,
    parameter int GUARD_CYCLES   = C_DEF_GUARD_CYCLES,
    parameter int DIST_W         = C_DEF_DIST_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [N_SENSORS-1:0]         echo_in,
    output logic [N_SENSORS-1:0]         trigger_out,
    output logic [DIST_W-1:0]            dist_cm,
    output logic [$clog2(N_SENSORS)-1:0] dist_id,
    output logic                         dist_valid,
    output logic                         dist_timeout,
    output logic                         busy
);

    localparam int IDX_W = $clog2(N_SENSORS);
    localparam int CNT_W = $clog2(max2(TRIG_CYCLES, GUARD_CYCLES) + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PRE_W = $clog2(CYCLES_PER_CM + 1);

    localparam logic [CNT_W-1:0] C_TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PRE_W-1:0] C_PRE_LAST   = PRE_W'(CYCLES_PER_CM - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(N_SENSORS - 1);

    scan_state_t state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;       // trigger width / guard gap
    logic [TMO_W-1:0]     tmo_q, tmo_d;       // trigger fall to echo fall
    logic [PRE_W-1:0]     pre_q, pre_d;       // cycles within current cm
    logic [DIST_W-1:0]    cm_q, cm_d;
    logic [N_SENSORS-1:0] trig_q, trig_d;
    logic [DIST_W-1:0]    dist_cm_q, dist_cm_d;
    logic [IDX_W-1:0]     dist_id_q, dist_id_d;
    logic                 dist_valid_q, dist_valid_d;
    logic                 dist_to_q, dist_to_d;
    logic                 busy_q, busy_d;

    logic                 res_load;
    logic                 res_to;
    logic [N_SENSORS-1:0] w_rise_vec;
    logic [N_SENSORS-1:0] w_fall_vec;
    logic                 w_rise;
    logic                 w_fall;

    generate
        for (genvar i = 0; i < N_SENSORS; i++) begin : g_sync
            echo_sync u_echo_sync (
                .clk     (clk),
                .reset   (reset),
                .echo_in (echo_in[i]),
                .rise    (w_rise_vec[i]),
                .fall    (w_fall_vec[i])
            );
        end
    endgenerate

    // Only the currently selected sensor's echo edges matter
    assign w_rise = w_rise_vec[idx_q];
    assign w_fall = w_fall_vec[idx_q];

    // Next-state, counter and result logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        pre_d    = pre_q;
        cm_d     = cm_q;
        res_load = 1'b0;
        res_to   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                end
            end
            TRIG: begin
                if (cnt_q == C_TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RISE: begin
                tmo_d = tmo_q + 1'b1;
                // An echo already high on entry never produces a rise here
                if (w_rise) begin
                    state_d = MEASURE;
                    pre_d   = '0;
                    cm_d    = '0;
                end else if (tmo_q >= C_TMO_LAST) begin
                    state_d  = REPORT;
                    res_load = 1'b1;
                    res_to   = 1'b1;
                end
            end
            MEASURE: begin
                tmo_d = tmo_q + 1'b1;
                // Whole centimetres only; the prescaler remainder is dropped
                if (pre_q == C_PRE_LAST) begin
                    pre_d = '0;
                    if (cm_q != '1) begin
                        cm_d = cm_q + 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                // A fall coinciding with the limit still counts as a real echo
                if (w_fall) begin
                    state_d  = REPORT;
                    res_load = 1'b1;
                end else if (tmo_q >= C_TMO_LAST) begin
                    state_d  = REPORT;
                    res_load = 1'b1;
                    res_to   = 1'b1;
                end
            end
            REPORT: begin
                state_d = GUARD;
                cnt_d   = '0;
            end
            GUARD: begin
                if (cnt_q == C_GUARD_LAST) begin
                    cnt_d   = '0;
                    idx_d   = (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
                    state_d = enable ? TRIG : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs, computed from the upcoming state so they change cleanly
    always_comb begin
        dist_cm_d    = dist_cm_q;
        dist_id_d    = dist_id_q;
        dist_to_d    = dist_to_q;
        dist_valid_d = res_load;
        if (res_load) begin
            dist_cm_d = res_to ? '1 : cm_d;
            dist_id_d = idx_q;
            dist_to_d = res_to;
        end
        busy_d = (state_d != IDLE);
        trig_d = '0;
        if (state_d == TRIG) begin
            trig_d[idx_d] = 1'b1;
        end
    end

    // State and datapath registers; reset drops the trigger immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            pre_q        <= '0;
            cm_q         <= '0;
            trig_q       <= '0;
            dist_cm_q    <= '0;
            dist_id_q    <= '0;
            dist_valid_q <= 1'b0;
            dist_to_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            pre_q        <= pre_d;
            cm_q         <= cm_d;
            trig_q       <= trig_d;
            dist_cm_q    <= dist_cm_d;
            dist_id_q    <= dist_id_d;
            dist_valid_q <= dist_valid_d;
            dist_to_q    <= dist_to_d;
            busy_q       <= busy_d;
        end
    end

    assign trigger_out  = trig_q;
    assign dist_cm      = dist_cm_q;
    assign dist_id      = dist_id_q;
    assign dist_valid   = dist_valid_q;
    assign dist_timeout = dist_to_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire
